// File: rtl/uop_sequencer_if.sv
// Shared decode/micro-op types and the decoder-to-register-read handshake bundle.
// master drives instructions, flush and out_ready; slave is the sequencer.
package uop_pkg;
  typedef logic [4:0] reg_id_t;

  typedef enum logic [1:0] {OPND_NIL, OPND_REG, OPND_MEM, OPND_IMM} opnd_kind_t;

  typedef struct packed {
    opnd_kind_t kind;
    reg_id_t    base_reg;
    reg_id_t    index_reg;
  } operand_t;

  typedef struct packed {
    operand_t    operand0;
    operand_t    operand1;
    logic [1:0]  scale;
    logic [31:0] disp;
    logic [31:0] immediate;
    logic [31:0] rip_val;
  } fat_instruction_t;

  typedef enum logic [4:0] {
    m_nop = 5'd0, m_add, m_sub, m_and, m_or, m_xor, m_cpy, m_lea, m_ld, m_st, m_syscall,
    m_jmp = 5'd16, m_jz, m_jnz, m_call
  } micro_opcode_t;

  // Control-flow opcodes lie strictly between these two bounds.
  localparam logic [4:0] M_JMIN = 5'd15;
  localparam logic [4:0] M_JMAX = 5'd20;

  typedef struct packed {
    micro_opcode_t opcode;
    reg_id_t       src0_id;
    reg_id_t       src1_id;
    reg_id_t       dst_id;
    logic [31:0]   src0_val;
    logic [31:0]   src1_val;
    logic [1:0]    scale;
    logic [31:0]   disp;
    logic [31:0]   immediate;
    logic [31:0]   rip_val;
  } micro_op_t;
endpackage

interface uop_sequencer_if;
  import uop_pkg::*;
  logic             in_valid;
  logic             in_ready;
  fat_instruction_t in_inst;
  micro_opcode_t    in_op;
  logic             out_valid;
  logic             out_ready;
  micro_op_t        out_uop;
  logic             out_last;
  logic             flush;

  modport master (output in_valid, in_inst, in_op, out_ready, flush,
                  input  in_ready, out_valid, out_uop, out_last);
  modport slave  (input  in_valid, in_inst, in_op, out_ready, flush,
                  output in_ready, out_valid, out_uop, out_last);
endinterface

// File: rtl/uop_sequencer.sv
// Cracks one decoded instruction into 1-3 micro-ops, one per cycle, registered output.
// Optional UOP_SEQ_PERF_EN adds perf_insts/perf_uops handshake counters.
module uop_sequencer
  import uop_pkg::*;
#(
  parameter reg_id_t TMP_REG = 5'd31
) (
  input  logic clk,
  input  logic reset_n,
  uop_sequencer_if.slave bus
`ifdef UOP_SEQ_PERF_EN
  ,
  output logic [31:0] perf_insts,
  output logic [31:0] perf_uops
`endif
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t           state, state_nxt;
  logic [1:0]       idx, n_cnt;
  fat_instruction_t held_inst;
  micro_opcode_t    held_op;
  logic             hs, last_hs, accept;

  function automatic reg_id_t bid(operand_t o);
    return (o.kind == OPND_NIL) ? '0 : o.base_reg;
  endfunction

  function automatic reg_id_t xid(operand_t o);
    return (o.kind == OPND_NIL) ? '0 : o.index_reg;
  endfunction

  function automatic logic is_ctl(micro_opcode_t a);
    return ((a > M_JMIN) && (a < M_JMAX)) || (a == m_syscall);
  endfunction

  function automatic logic [1:0] uop_count(fat_instruction_t i, micro_opcode_t a);
    logic [1:0] c;
    c = 2'd1;
    if (!is_ctl(a) && (a != m_lea) && (a != m_cpy)) begin
      if (i.operand0.kind == OPND_MEM)
        c = 2'd3;
      else if ((i.operand0.kind == OPND_REG) && (i.operand1.kind == OPND_MEM))
        c = 2'd2;
    end
    return c;
  endfunction

  function automatic micro_op_t crack(fat_instruction_t i, micro_opcode_t a, logic [1:0] k);
    micro_op_t u;
    operand_t  d, s;
    d           = i.operand0;
    s           = i.operand1;
    u           = '0;
    u.scale     = i.scale;
    u.disp      = i.disp;
    u.immediate = i.immediate;
    u.rip_val   = i.rip_val;
    u.opcode    = a;
    u.src0_id   = bid(d);
    u.src1_id   = bid(s);
    u.dst_id    = bid(d);
    if (is_ctl(a)) begin
      // register form already loaded
    end else if (a == m_lea) begin
      u.src0_id = bid(s);
      u.src1_id = xid(s);
    end else if ((a == m_cpy) && (d.kind == OPND_MEM)) begin
      u.opcode  = m_st;
      u.src0_id = bid(d);
      u.src1_id = xid(d);
      u.dst_id  = bid(s);
    end else if ((a == m_cpy) && (s.kind == OPND_MEM)) begin
      u.opcode  = m_ld;
      u.src0_id = bid(s);
      u.src1_id = xid(s);
    end else if ((d.kind == OPND_REG) && (s.kind == OPND_MEM)) begin
      if (k == 2'd0) begin
        u.opcode  = m_ld;
        u.src0_id = bid(s);
        u.src1_id = xid(s);
        u.dst_id  = TMP_REG;
      end else begin
        u.src1_id = TMP_REG;
      end
    end else if (d.kind == OPND_MEM) begin
      // load-modify-store through the scratch register
      u.dst_id = TMP_REG;
      if (k == 2'd1) begin
        u.src0_id = TMP_REG;
      end else begin
        u.opcode  = (k == 2'd0) ? m_ld : m_st;
        u.src0_id = bid(d);
        u.src1_id = xid(d);
      end
    end
    return u;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_nxt = S_EMIT;
        S_EMIT:  if (last_hs && !accept) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    hs           = bus.out_valid && bus.out_ready;
    last_hs      = hs && bus.out_last;
    bus.in_ready = reset_n && !bus.flush &&
                   ((state == S_IDLE) || (bus.out_last && bus.out_ready));
    accept       = bus.in_valid && bus.in_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_uop   <= '0;
      idx           <= 2'd0;
      n_cnt         <= 2'd0;
      held_inst     <= '0;
      held_op       <= m_nop;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      idx           <= 2'd0;
    end else if (accept) begin
      held_inst     <= bus.in_inst;
      held_op       <= bus.in_op;
      n_cnt         <= uop_count(bus.in_inst, bus.in_op);
      idx           <= 2'd0;
      bus.out_uop   <= crack(bus.in_inst, bus.in_op, 2'd0);
      bus.out_last  <= (uop_count(bus.in_inst, bus.in_op) == 2'd1);
      bus.out_valid <= 1'b1;
    end else if (last_hs) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      idx           <= 2'd0;
    end else if (hs) begin
      idx           <= idx + 2'd1;
      bus.out_uop   <= crack(held_inst, held_op, idx + 2'd1);
      bus.out_last  <= (({1'b0, idx} + 3'd2) == {1'b0, n_cnt});
    end
  end

`ifdef UOP_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_insts <= '0;
      perf_uops  <= '0;
    end else begin
      if (hs)      perf_uops  <= perf_uops + 32'd1;
      if (last_hs) perf_insts <= perf_insts + 32'd1;
    end
  end
`endif

endmodule
